pipe_seq_ctrl: RTL

//  Sequencer for the N-stage count-up pipeline. It generates the per-stage enables stage_en and the fetch strobe.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_sat_cnt.sv | 32 +++
 rtl/pipe_seq_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared types and default sizing for the pipeline sequencer.
//   state_t    : sequencer FSM encoding (IDLE/FILL/RUN/DRAIN)
//   STAGES_DEF : default pipeline depth
//   CNT_W_DEF  : default width of run length and counters
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int STAGES_DEF = 4;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt
//   Saturating up-counter with synchronous clear. A clear that coincides
//   with an increment loads 1, so the event in the clearing cycle is counted.
// Ports
//   CLK  in   clock
//   RST  in   synchronous reset, active-high
//   clr  in   restart the count
//   inc  in   count one event
//   cnt  out  current count, sticks at all-ones
module pipe_sat_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl
//   Sequencer for the N-stage count-up pipeline: fills the stage enables,
//   keeps injecting while running, then drains. Supports stall hold, flush
//   abort, a programmable op count and done/aborted status pulses.
//   Optional build macro PIPE_PERF_CNT_EN adds stall_cycles/run_cycles.
// Ports
//   CLK          in   clock
//   RST          in   synchronous reset, active-high
//   start        in   begin a run (IDLE only)
//   stop         in   end injection, pipeline drains
//   stall        in   freeze contents and state this cycle
//   flush        in   abort, clear all stages
//   run_len      in   ops per run, 0 = unlimited; sampled at start
//   stage_en     out  bit i = stage i holds a valid op
//   fetch_en     out  comb: op injected into stage 0 this cycle
//   busy         out  state != IDLE
//   done         out  pulse: drain completed normally
//   aborted      out  pulse: run ended by flush
//   issued_cnt   out  ops injected in current/last run
//   stall_cycles out  (PIPE_PERF_CNT_EN) busy & stall cycles
//   run_cycles   out  (PIPE_PERF_CNT_EN) busy cycles
//
// state | meaning
// IDLE  | no run active, waiting for start
// FILL  | injecting, stages not all valid yet
// RUN   | injecting, all stages valid
// DRAIN | no injection, shifting zeros until empty
module pipe_seq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              stop,
  input  logic              stall,
  input  logic              flush,
  input  logic [CNT_W-1:0]  run_len,
  output logic [STAGES-1:0] stage_en,
  output logic              fetch_en,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  issued_cnt
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  run_cycles
`endif
);

  state_t            state_q, state_d;
  logic [STAGES-1:0] stage_q, stage_d, stage_sh;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              stop_pend_q, stop_pend_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  logic busy_w, run_phase, stop_eff, lim, last_op, accept;

  assign busy_w    = (state_q != IDLE);
  assign run_phase = (state_q == FILL) || (state_q == RUN);
  assign stop_eff  = stop || stop_pend_q;
  assign lim       = run_phase && (len_q != '0) && (issued_cnt == len_q);
  assign accept    = (state_q == IDLE) && start && !stall && !flush;

  // Stop only gates injection once a run is underway; start+stop in IDLE
  // still issues one op.
  assign fetch_en  = accept ||
                     (run_phase && !flush && !stall && !stop_eff && !lim);

  // Leave for DRAIN on the edge of the final op, so nothing idles in FILL/RUN.
  assign last_op   = run_phase && fetch_en && (len_q != '0) &&
                     (issued_cnt == (len_q - CNT_W'(1)));

  assign stage_sh  = {stage_q[STAGES-2:0], fetch_en};

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    len_d       = len_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    if (flush) begin
      if (busy_w) begin
        state_d     = IDLE;
        stage_d     = '0;
        stop_pend_d = 1'b0;
        aborted_d   = 1'b1;
      end
    end else if (stall) begin
      if (run_phase && stop) begin
        stop_pend_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_d   = run_len;
            stage_d = stage_sh;
            state_d = (stop || (run_len == CNT_W'(1))) ? DRAIN : FILL;
          end
        end
        FILL, RUN: begin
          stage_d = stage_sh;
          if (stop_eff || lim || last_op) begin
            state_d     = DRAIN;
            stop_pend_d = 1'b0;
          end else if ((state_q == FILL) && (stage_sh == '1)) begin
            state_d = RUN;
          end
        end
        DRAIN: begin
          stage_d     = stage_sh;
          stop_pend_d = 1'b0;
          if (stage_sh == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      len_q       <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      len_q       <= len_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_issued (
    .CLK (CLK),
    .RST (RST),
    .clr (accept),
    .inc (fetch_en),
    .cnt (issued_cnt)
  );

`ifdef PIPE_PERF_CNT_EN
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_run_cycles (
    .CLK (CLK),
    .RST (RST),
    .clr (accept),
    .inc (busy_w),
    .cnt (run_cycles)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cycles (
    .CLK (CLK),
    .RST (RST),
    .clr (accept),
    .inc (busy_w && stall),
    .cnt (stall_cycles)
  );
`else
  // Performance counters not built.
`endif

  assign stage_en = stage_q;
  assign busy     = busy_w;
  assign done     = done_q;
  assign aborted  = aborted_q;

endmodule
